fetch_stage: RTL



---
 rtl/fetch_pkg.sv | 27 ++
 rtl/fetch_stage_if.sv | 49 ++++
 rtl/fetch_stage_sync_fifo.sv | 58 +++++
 rtl/fetch_stage.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the rv32i fetch front end.
//   fetch_entry_t : one decoded-side entry {pc, instr, fault}
//   NOP           : addi x0,x0,0, used as the payload of a fault entry
//   fetch_state_e : halt FSM states (used when FETCH_MISALIGN_EN is defined)
package fetch_pkg;

  localparam int XLEN_W = 32;

  localparam logic [XLEN_W-1:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic [XLEN_W-1:0] pc;
    logic [XLEN_W-1:0] instr;
    logic              fault;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  // RUN: fetching. DRAIN: misaligned redirect seen, waiting for dropped
  // responses to retire before pushing the fault entry. HALT: parked.
  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/fetch_stage_if.sv
// fetch_stage_if: all non-clock/reset signals of fetch_stage.
//   imem request : o_imem_req_valid / i_imem_req_ready / o_imem_addr
//   imem response: i_imem_rsp_valid / i_imem_rsp_data (in order, no backpressure)
//   redirect     : i_redirect_valid / i_redirect_pc
//   decode side  : o_valid / i_ready / o_pc / o_instr (/ o_fault)
// Modports: master = fetch stage, slave = its environment.
// Macro FETCH_MISALIGN_EN adds o_fault.
interface fetch_stage_if #(
  parameter int XLEN = 32
);
  logic            o_imem_req_valid;
  logic            i_imem_req_ready;
  logic [XLEN-1:0] o_imem_addr;
  logic            i_imem_rsp_valid;
  logic [XLEN-1:0] i_imem_rsp_data;
  logic            i_redirect_valid;
  logic [XLEN-1:0] i_redirect_pc;
  logic            o_valid;
  logic            i_ready;
  logic [XLEN-1:0] o_pc;
  logic [XLEN-1:0] o_instr;

`ifdef FETCH_MISALIGN_EN
  logic            o_fault;

  modport master (
    output o_imem_req_valid, o_imem_addr, o_valid, o_pc, o_instr, o_fault,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
           i_redirect_valid, i_redirect_pc, i_ready
  );
  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_valid, o_pc, o_instr, o_fault,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
           i_redirect_valid, i_redirect_pc, i_ready
  );
`else
  modport master (
    output o_imem_req_valid, o_imem_addr, o_valid, o_pc, o_instr,
    input  i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
           i_redirect_valid, i_redirect_pc, i_ready
  );
  modport slave (
    input  o_imem_req_valid, o_imem_addr, o_valid, o_pc, o_instr,
    output i_imem_req_ready, i_imem_rsp_valid, i_imem_rsp_data,
           i_redirect_valid, i_redirect_pc, i_ready
  );
`endif

endinterface

// File: rtl/fetch_stage_sync_fifo.sv
// sync_fifo: first-word-fallthrough register FIFO with synchronous flush.
//   clk, rstn : clock, synchronous active-low reset
//   flush     : empty the FIFO (wins over push/pop)
//   push, din : write
//   pop       : consume head (ignored when empty)
//   dout      : head entry, 0 when empty
//   count     : occupancy, empty, full
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int DLEN  = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic                       flush,
  input  logic                       push,
  input  logic [DLEN-1:0]            din,
  input  logic                       pop,
  output logic [DLEN-1:0]            dout,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       empty,
  output logic                       full
);
  localparam int AW = $clog2(DEPTH);

  logic [DLEN-1:0] mem [DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [AW:0]     cnt;
  logic            do_pop;

  assign empty  = (cnt == '0);
  assign full   = (cnt == (AW+1)'(DEPTH));
  assign do_pop = pop && !empty;
  assign count  = cnt;
  assign dout   = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + AW'(1);
      if (do_pop) rd_ptr <= rd_ptr + AW'(1);
      cnt <= cnt + (AW+1)'(push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && !flush && push) mem[wr_ptr] <= din;
  end

  // Writers are credit-limited; a push into a full FIFO without a pop
  // means the credit accounting upstream is broken.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rstn)
    !(push && full && !do_pop && !flush));

endmodule

// File: rtl/fetch_stage.sv
// fetch_stage: rv32i instruction fetch front end.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : fetch_stage_if.master (imem request/response, redirect,
//               {pc, instr} valid/ready towards decode)
// Sequential PCs are issued while inflight + queued < DEPTH, so every
// response always has a queue slot. The PC of each request is parked in a
// side FIFO until its response returns. A redirect flushes both FIFOs and
// turns everything still in flight into drops counted by drop_cnt.
// Macro FETCH_MISALIGN_EN: a misaligned redirect halts fetch and, once the
// drops retire, emits one fault entry {redirect_pc, NOP, fault=1}.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input logic          clk,
  input logic          rstn,
  fetch_stage_if.master bus
);
  localparam int             CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0]    DEPTH_L = (CW+1)'(DEPTH);

  logic [XLEN-1:0] pc;
  logic [CW-1:0]   inflight, drop_cnt;
  logic [CW-1:0]   count, pcq_count;
  logic            redir, rsp_valid, rsp_keep, req_fire, credit_ok;
  logic            fetch_en, fault_push;
  fetch_entry_t    q_din, q_dout;
  logic            q_empty, q_full, pcq_empty, pcq_full;
  logic [XLEN-1:0] pcq_head;

  assign redir     = bus.i_redirect_valid;
  assign rsp_valid = bus.i_imem_rsp_valid;
  // Responses during a redirect or owed to a flushed request are dropped.
  assign rsp_keep  = rsp_valid && (drop_cnt == '0) && !redir;
  assign credit_ok = ({1'b0, inflight} + {1'b0, count}) < DEPTH_L;

  assign bus.o_imem_req_valid = rstn && fetch_en && !redir && credit_ok;
  assign bus.o_imem_addr      = pc;
  assign req_fire             = bus.o_imem_req_valid && bus.i_imem_req_ready;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      pc       <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
    end else if (redir) begin
      pc       <= {bus.i_redirect_pc[XLEN-1:2], 2'b00};
      inflight <= inflight - CW'(rsp_valid);
      drop_cnt <= inflight - CW'(rsp_valid);
    end else begin
      if (req_fire) pc <= pc + XLEN'(4);
      inflight <= inflight + CW'(req_fire) - CW'(rsp_valid);
      if (rsp_valid && drop_cnt != '0) drop_cnt <= drop_cnt - CW'(1);
    end
  end

`ifdef FETCH_MISALIGN_EN
  fetch_state_e    state, state_nx;
  logic [XLEN-1:0] fault_pc;
  logic            misaligned;

  assign misaligned = redir && (bus.i_redirect_pc[1:0] != 2'b00);

  always_ff @(posedge clk) begin
    if (!rstn) state <= ST_RUN;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rstn)           fault_pc <= '0;
    else if (misaligned) fault_pc <= bus.i_redirect_pc;
  end

  always_comb begin
    state_nx = state;
    if (redir)                                    state_nx = misaligned ? ST_DRAIN : ST_RUN;
    else if (state == ST_DRAIN && drop_cnt == '0) state_nx = ST_HALT;
  end

  // No requests leave while halted, so drop_cnt == 0 also means nothing is
  // in flight and the flushed queue has room for the fault entry.
  always_comb begin
    fetch_en   = (state == ST_RUN);
    fault_push = (state == ST_DRAIN) && (drop_cnt == '0) && !redir;
  end
`else
  assign fetch_en   = 1'b1;
  assign fault_push = 1'b0;
`endif

  always_comb begin
    q_din = '{pc: pcq_head, instr: bus.i_imem_rsp_data, fault: 1'b0};
`ifdef FETCH_MISALIGN_EN
    if (fault_push) q_din = '{pc: fault_pc, instr: NOP, fault: 1'b1};
`endif
  end

  sync_fifo #(.DLEN(XLEN), .DEPTH(DEPTH)) u_pcq (
    .clk   (clk),
    .rstn  (rstn),
    .flush (redir),
    .push  (req_fire),
    .din   (pc),
    .pop   (rsp_keep),
    .dout  (pcq_head),
    .count (pcq_count),
    .empty (pcq_empty),
    .full  (pcq_full)
  );

  sync_fifo #(.DLEN(ENTRY_W), .DEPTH(DEPTH)) u_q (
    .clk   (clk),
    .rstn  (rstn),
    .flush (redir),
    .push  (rsp_keep || fault_push),
    .din   (q_din),
    .pop   (bus.i_ready),
    .dout  (q_dout),
    .count (count),
    .empty (q_empty),
    .full  (q_full)
  );

  assign bus.o_valid = rstn && !q_empty;
  assign bus.o_pc    = q_dout.pc;
  assign bus.o_instr = q_dout.instr;

`ifdef FETCH_MISALIGN_EN
  assign bus.o_fault = q_dout.fault;
  logic unused_sig;
  assign unused_sig = ^{q_full, pcq_full, pcq_empty, pcq_count};
`else
  logic unused_sig;
  assign unused_sig = ^{q_full, pcq_full, pcq_empty, pcq_count,
                        q_dout.fault, bus.i_redirect_pc[1:0]};
`endif

endmodule
